// File: rtl/eth_txbuf_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eth_txbuf_pkg : shared types and constants for the TX frame-buffer scheduler
// Revision      : 1.0
// ----------------------------------------------------------------------------
package eth_txbuf_pkg;

  localparam int unsigned TXB_ADDR_W    = 13;
  localparam int unsigned TXB_SLOT_BITS = 2;
  localparam int unsigned SLOT_HW       = 1 << (TXB_ADDR_W - TXB_SLOT_BITS);

  typedef struct packed {
    logic [TXB_SLOT_BITS-1:0] slot;
    logic [TXB_ADDR_W-1:0]    len;
  } desc_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/eth_txbuf_desc_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eth_txbuf_desc_fifo : synchronous descriptor FIFO with flush
// Revision            : 1.0
// ----------------------------------------------------------------------------
module eth_txbuf_desc_fifo
  import eth_txbuf_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DESC_W = $bits(desc_t)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DESC_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DESC_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  desc_t            r_mem [DEPTH];
  logic [PTR_W:0]   r_wp;
  logic [PTR_W:0]   r_rp;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[PTR_W] != r_rp[PTR_W]) &&
                   (r_wp[PTR_W-1:0] == r_rp[PTR_W-1:0]);
  assign o_data  = r_mem[r_rp[PTR_W-1:0]];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push = i_push & (~o_full | i_pop);
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + (PTR_W+1)'(1);
      if (w_pop)  r_rp <= r_rp + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush && !rst) r_mem[r_wp[PTR_W-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/eth_txbuf_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eth_txbuf_sched : queues (slot,len) descriptors and streams frames from the
//                   16-bit buffer port to an AXI-stream MAC interface
// Revision        : 1.0
// ----------------------------------------------------------------------------
module eth_txbuf_sched
  import eth_txbuf_pkg::*;
#(
  parameter int unsigned ADDR_W     = TXB_ADDR_W,
  parameter int unsigned SLOT_BITS  = TXB_SLOT_BITS,
  parameter int unsigned DESC_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_desc_valid,
  output logic                 o_desc_ready,
  input  logic [SLOT_BITS-1:0] i_desc_slot,
  input  logic [ADDR_W-1:0]    i_desc_len,
  input  logic                 i_abort,
  output logic                 o_mem_en,
  output logic [ADDR_W-1:0]    o_mem_addr,
  input  logic [15:0]          i_mem_rdata,
  output logic [15:0]          o_tx_tdata,
  output logic [1:0]           o_tx_tkeep,
  output logic                 o_tx_tlast,
  output logic                 o_tx_tvalid,
  input  logic                 i_tx_tready,
  output logic                 o_done_valid,
  output logic [SLOT_BITS-1:0] o_done_slot,
  output logic                 o_done_err,
  output logic                 o_busy
);

  localparam int unsigned MAX_LEN = 1 << (ADDR_W - SLOT_BITS + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  desc_t              w_desc_in;
  desc_t              w_q_head;
  desc_t              r_cur;
  logic               w_q_full;
  logic               w_q_empty;
  logic               w_push_desc;
  logic               w_pop_desc;
  logic               w_len_bad;
  logic               w_in_frame;
  logic [ADDR_W:0]    w_len_p1;
  logic               r_err;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_hw_left;
  logic               w_hw_last;
  logic               r_rd_pend;
  logic               r_rd_last;
  logic [1:0]         r_rd_keep;
  logic [15:0]        w_rd_data;
  logic [15:0]        r_sk_data [2];
  logic [1:0]         r_sk_keep [2];
  logic               r_sk_last [2];
  logic               r_sk_wp;
  logic               r_sk_rp;
  logic [1:0]         r_sk_cnt;
  logic [1:0]         w_occ;
  logic               w_tx_pop;

  assign w_desc_in   = '{slot: i_desc_slot, len: i_desc_len};
  assign w_push_desc = i_desc_valid & ~w_q_full & ~i_abort;
  assign w_pop_desc  = (r_state == IDLE) & ~w_q_empty & ~i_abort;
  assign o_desc_ready = ~w_q_full;

  eth_txbuf_desc_fifo #(
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (i_abort),
    .i_push  (w_push_desc),
    .i_data  (w_desc_in),
    .i_pop   (w_pop_desc),
    .o_data  (w_q_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty)
  );

  assign w_len_bad  = (r_cur.len == '0) || (32'(r_cur.len) > MAX_LEN);
  assign w_len_p1   = {1'b0, r_cur.len} + (ADDR_W+1)'(1);
  assign w_in_frame = (r_state == LOAD) || (r_state == STREAM);
  assign w_hw_last  = (r_hw_left == ADDR_W'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = w_in_frame ? DONE : IDLE;
    end else begin
      case (r_state)
        IDLE:    if (!w_q_empty) w_state_nxt = LOAD;
        LOAD:    w_state_nxt = w_len_bad ? DONE : STREAM;
        STREAM:  if (w_tx_pop && o_tx_tlast) w_state_nxt = DONE;
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // An entry leaving the skid this cycle counts as free, which keeps one
  // beat per cycle flowing with only two entries of buffering.
  assign w_tx_pop = o_tx_tvalid & i_tx_tready;
  assign w_occ    = r_sk_cnt + 2'(r_rd_pend) - 2'(w_tx_pop);
  assign o_mem_en = (r_state == STREAM) & (r_hw_left != '0) &
                    (w_occ < 2'd2) & ~i_abort;
  assign o_mem_addr = r_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur     <= '0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_hw_left <= '0;
      r_rd_pend <= 1'b0;
      r_rd_last <= 1'b0;
      r_rd_keep <= '0;
    end else begin
      r_rd_pend <= o_mem_en;
      if (w_pop_desc) r_cur <= w_q_head;
      if (r_state == LOAD) begin
        r_err     <= w_len_bad;
        r_addr    <= {r_cur.slot, {(ADDR_W-SLOT_BITS){1'b0}}};
        r_hw_left <= w_len_bad ? '0 : w_len_p1[ADDR_W:1];
      end
      if (o_mem_en) begin
        r_addr    <= r_addr + ADDR_W'(1);
        r_hw_left <= r_hw_left - ADDR_W'(1);
        r_rd_last <= w_hw_last;
        r_rd_keep <= (w_hw_last && r_cur.len[0]) ? 2'b01 : 2'b11;
      end
      if (i_abort) begin
        r_hw_left <= '0;
        if (w_in_frame) r_err <= 1'b1;
      end
    end
  end

  assign w_rd_data = (r_rd_keep == 2'b01) ? {8'h00, i_mem_rdata[7:0]} : i_mem_rdata;

  always_ff @(posedge clk) begin
    if (rst || i_abort) begin
      r_sk_wp  <= 1'b0;
      r_sk_rp  <= 1'b0;
      r_sk_cnt <= '0;
    end else begin
      if (r_rd_pend) r_sk_wp <= ~r_sk_wp;
      if (w_tx_pop)  r_sk_rp <= ~r_sk_rp;
      r_sk_cnt <= r_sk_cnt + 2'(r_rd_pend) - 2'(w_tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_sk_data[i] <= '0;
        r_sk_keep[i] <= '0;
        r_sk_last[i] <= 1'b0;
      end
    end else if (r_rd_pend && !i_abort) begin
      r_sk_data[r_sk_wp] <= w_rd_data;
      r_sk_keep[r_sk_wp] <= r_rd_keep;
      r_sk_last[r_sk_wp] <= r_rd_last;
    end
  end

  assign o_tx_tvalid = (r_sk_cnt != 2'd0);
  assign o_tx_tdata  = o_tx_tvalid ? r_sk_data[r_sk_rp] : '0;
  assign o_tx_tkeep  = o_tx_tvalid ? r_sk_keep[r_sk_rp] : '0;
  assign o_tx_tlast  = o_tx_tvalid & r_sk_last[r_sk_rp];

  assign o_done_valid = (r_state == DONE);
  assign o_done_slot  = o_done_valid ? r_cur.slot : '0;
  assign o_done_err   = o_done_valid & r_err;
  assign o_busy       = (r_state != IDLE) | ~w_q_empty;

endmodule
`default_nettype wire

// File: tb/tb_eth_txbuf_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_eth_txbuf_sched : directed + random bench with a frame-level reference model
// Revision           : 1.0
// ----------------------------------------------------------------------------
module tb_eth_txbuf_sched;

  logic        clk;
  logic        rst;
  logic        i_desc_valid;
  logic        o_desc_ready;
  logic [1:0]  i_desc_slot;
  logic [12:0] i_desc_len;
  logic        i_abort;
  logic        o_mem_en;
  logic [12:0] o_mem_addr;
  logic [15:0] i_mem_rdata;
  logic [15:0] o_tx_tdata;
  logic [1:0]  o_tx_tkeep;
  logic        o_tx_tlast;
  logic        o_tx_tvalid;
  logic        i_tx_tready;
  logic        o_done_valid;
  logic [1:0]  o_done_slot;
  logic        o_done_err;
  logic        o_busy;

  eth_txbuf_sched dut (
    .clk          (clk),
    .rst          (rst),
    .i_desc_valid (i_desc_valid),
    .o_desc_ready (o_desc_ready),
    .i_desc_slot  (i_desc_slot),
    .i_desc_len   (i_desc_len),
    .i_abort      (i_abort),
    .o_mem_en     (o_mem_en),
    .o_mem_addr   (o_mem_addr),
    .i_mem_rdata  (i_mem_rdata),
    .o_tx_tdata   (o_tx_tdata),
    .o_tx_tkeep   (o_tx_tkeep),
    .o_tx_tlast   (o_tx_tlast),
    .o_tx_tvalid  (o_tx_tvalid),
    .i_tx_tready  (i_tx_tready),
    .o_done_valid (o_done_valid),
    .o_done_slot  (o_done_slot),
    .o_done_err   (o_done_err),
    .o_busy       (o_busy)
  );

  typedef struct packed { logic [15:0] d; logic [1:0] k; logic l; } beat_t;
  typedef struct packed { logic [1:0] s; logic e; } cmp_t;

  logic [15:0] mem [8192];
  beat_t       beat_q [$];
  cmp_t        cmp_q [$];
  logic [12:0] addr_q [$];

  int n_chk   = 0;
  int n_fail  = 0;
  int n_beats = 0;
  int n_iss   = 0;
  int n_acc   = 0;
  int tr_mode = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous RAM: data is valid exactly one cycle after the read enable.
  always @(posedge clk) i_mem_rdata <= o_mem_en ? mem[o_mem_addr] : 16'($urandom);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    case (tr_mode)
      0:       i_tx_tready = 1'b1;
      1:       i_tx_tready = ~i_tx_tready;
      2:       i_tx_tready = 1'($urandom_range(0, 1));
      default: i_tx_tready = 1'b0;
    endcase
  endtask

  task automatic model_push(input logic [1:0] slot, input logic [12:0] len);
    int          n;
    logic [12:0] base;
    beat_t       b;
    if (len == 13'd0 || len > 13'd4096) begin
      cmp_q.push_back('{s: slot, e: 1'b1});
    end else begin
      base = {slot, 11'h000};
      n = (int'(len) + 1) / 2;
      for (int i = 0; i < n; i++) begin
        addr_q.push_back(base + 13'(i));
        b.d = mem[base + 13'(i)];
        b.l = (i == n - 1);
        b.k = (b.l && len[0]) ? 2'b01 : 2'b11;
        if (b.k == 2'b01) b.d[15:8] = 8'h00;
        beat_q.push_back(b);
      end
      cmp_q.push_back('{s: slot, e: 1'b0});
    end
  endtask

  task automatic post(input logic [1:0] slot, input logic [12:0] len);
    int t = 0;
    i_desc_valid = 1'b1;
    i_desc_slot  = slot;
    i_desc_len   = len;
    while (!o_desc_ready && t < 300) begin
      step();
      t++;
    end
    chk("post_ready", 32'(o_desc_ready), 32'd1);
    model_push(slot, len);
    step();
    i_desc_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((o_busy || beat_q.size() != 0 || cmp_q.size() != 0) && t < budget) begin
      step();
      t++;
    end
    chk("idle_in_time", 32'(t < budget), 32'd1);
    chk("beats_left", 32'(beat_q.size()), 32'd0);
    chk("completions_left", 32'(cmp_q.size()), 32'd0);
  endtask

  beat_t       b_exp;
  cmp_t        c_exp;
  logic [12:0] a_exp;
  logic        p_hold;
  logic [18:0] p_beat;

  always @(negedge clk) begin
    if (rst) begin
      p_hold = 1'b0;
      n_iss  = 0;
      n_acc  = 0;
    end else begin
      if (p_hold) begin
        chk("hold_tvalid", 32'(o_tx_tvalid), 32'd1);
        chk("hold_beat", 32'({o_tx_tdata, o_tx_tkeep, o_tx_tlast}), 32'(p_beat));
      end
      p_hold = o_tx_tvalid && !i_tx_tready && !i_abort;
      p_beat = {o_tx_tdata, o_tx_tkeep, o_tx_tlast};
      if (o_tx_tvalid && i_tx_tready) begin
        n_acc++;
        n_beats++;
        chk("beat_expected", 32'(beat_q.size() != 0), 32'd1);
        if (beat_q.size() != 0) begin
          b_exp = beat_q.pop_front();
          chk("tdata", 32'(o_tx_tdata), 32'(b_exp.d));
          chk("tkeep", 32'(o_tx_tkeep), 32'(b_exp.k));
          chk("tlast", 32'(o_tx_tlast), 32'(b_exp.l));
        end
      end
      if (o_mem_en) begin
        chk("read_window", 32'((n_iss - n_acc) < 2), 32'd1);
        n_iss++;
        chk("read_expected", 32'(addr_q.size() != 0), 32'd1);
        if (addr_q.size() != 0) begin
          a_exp = addr_q.pop_front();
          chk("mem_addr", 32'(o_mem_addr), 32'(a_exp));
        end
      end
      if (o_done_valid) begin
        chk("done_expected", 32'(cmp_q.size() != 0), 32'd1);
        if (cmp_q.size() != 0) begin
          c_exp = cmp_q.pop_front();
          chk("done_slot", 32'(o_done_slot), 32'(c_exp.s));
          chk("done_err", 32'(o_done_err), 32'(c_exp.e));
        end
      end
      // Anything buffered or in flight at an abort is discarded by the DUT.
      if (i_abort) n_iss = n_acc;
    end
  end

  int   b0;
  int   t;
  cmp_t c_cur;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    mem[13'h0800] = 16'h1100;
    mem[13'h0801] = 16'h3322;
    mem[13'h0802] = 16'h5544;
    mem[13'h1000] = 16'h2211;
    mem[13'h1001] = 16'h4433;
    mem[13'h1002] = 16'h6655;
    i_desc_valid = 1'b0;
    i_desc_slot  = '0;
    i_desc_len   = '0;
    i_abort      = 1'b0;
    i_tx_tready  = 1'b1;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_desc_ready", 32'(o_desc_ready), 32'd1);
    chk("rst_tvalid", 32'(o_tx_tvalid), 32'd0);
    chk("rst_mem_en", 32'(o_mem_en), 32'd0);
    chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_tx_beat", 32'({o_tx_tdata, o_tx_tkeep, o_tx_tlast}), 32'd0);
    chk("rst_done", 32'({o_done_valid, o_done_slot, o_done_err}), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    rst = 1'b0;

    // Even and odd length frames with the MAC always ready.
    tr_mode = 0;
    post(2'd1, 13'd6);
    wait_idle(200);
    post(2'd2, 13'd5);
    wait_idle(200);

    // Back-pressure toggling every cycle.
    tr_mode = 1;
    post(2'd0, 13'd64);
    wait_idle(400);

    // Five back-to-back descriptors: the first is popped, four fill the queue.
    tr_mode = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("ready_before_push", 32'(o_desc_ready), 32'd1);
      post(2'(i), 13'(20 - 3 * i));
    end
    chk("ready_when_full", 32'(o_desc_ready), 32'd0);
    wait_idle(600);

    // Length boundaries: rejected descriptors, then a normal frame and a full slot.
    post(2'd3, 13'd0);
    post(2'd0, 13'd4097);
    post(2'd1, 13'd7);
    wait_idle(300);
    post(2'd3, 13'd4096);
    wait_idle(2500);

    // Abort mid-frame with two descriptors queued and one offered in the abort cycle.
    b0 = n_beats;
    post(2'd0, 13'd40);
    post(2'd1, 13'd10);
    post(2'd2, 13'd10);
    t = 0;
    while ((n_beats - b0) < 10 && t < 200) begin
      step();
      t++;
    end
    chk("abort_reached", 32'(t < 200), 32'd1);
    chk("beats_before_abort", 32'(n_beats - b0), 32'd10);
    tr_mode      = 3;
    i_tx_tready  = 1'b0;
    i_abort      = 1'b1;
    i_desc_valid = 1'b1;
    i_desc_slot  = 2'd3;
    i_desc_len   = 13'd8;
    c_cur   = cmp_q[0];
    c_cur.e = 1'b1;
    cmp_q.delete();
    cmp_q.push_back(c_cur);
    beat_q.delete();
    addr_q.delete();
    step();
    i_abort      = 1'b0;
    i_desc_valid = 1'b0;
    chk("abort_tvalid", 32'(o_tx_tvalid), 32'd0);
    chk("abort_mem_en", 32'(o_mem_en), 32'd0);
    chk("abort_ready", 32'(o_desc_ready), 32'd1);
    step();
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_completions", 32'(cmp_q.size()), 32'd0);
    tr_mode = 0;
    repeat (4) step();
    post(2'd1, 13'd6);
    wait_idle(200);

    // Random descriptors with random back-pressure.
    tr_mode = 2;
    for (int i = 0; i < 12; i++) begin
      int r;
      r = $urandom_range(0, 9);
      post(2'($urandom_range(0, 3)),
           (r == 0) ? 13'd0 :
           (r == 1) ? 13'($urandom_range(4097, 8191)) :
                      13'($urandom_range(1, 90)));
    end
    wait_idle(4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
